div_ctrl: RTL and testbench
===========================

# div_ctrl

Issue and completion controller for the iterative radix-2 divider in the RV32 execute stage. It accepts one DIV/DIVU/REM/REMU request at a time from the issue side with a valid/ready handshake. It latches the operands and starts the divider, holding the divider inputs stable until it completes. The result is held in an output register until writeback accepts it, and a pipeline kill retires an in-flight divide safely.

## Interface
- No parameters.
- `clk`  in  1  core clock
- `rstn`  in  1  asynchronous active-low reset
- `flush`  in  1  pipeline kill; discards accepted/in-flight request
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`
- `req_op`  in  3  funct3: DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111
- `req_op1`, `req_op2`  in  32  dividend, divisor
- `req_rd`  in  5  destination register tag
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  writeback accepts result
- `rsp_data`  out  32  quotient or remainder
- `rsp_rd`  out  5  tag of result
- `busy`  out  1  any state other than IDLE
- `div_valid`  out  1  divider start request
- `div_stall`  out  1  divider stall (driven 0 except as stated)
- `div_ready`  in  1  divider completion strobe (single cycle)
- `div_op`  out  3  held funct3 to divider
- `div_op1`, `div_op2`  out  32  held operands to divider
- `div_out`  in  32  divider result, valid while `div_ready`=1

## Operation
- States: IDLE, RUN, DRAIN, RESP (2-bit encoded, reset IDLE).
- Reset values: all outputs 0; operand/op/tag/result registers 0.
- `req_ready` = (IDLE | (RESP & `rsp_ready`)) & ~`flush`.
- On accept: latch `req_op`/`req_op1`/`req_op2`/`req_rd` into hold registers; `div_op`/`div_op1`/`div_op2` come from the hold registers only, constant until leaving RUN/DRAIN. Go to RUN.
- RUN: `div_valid`=1 for exactly the first RUN cycle (start pulse), then 0. On `div_ready`, capture `div_out` into the result register and go to RESP.
- RESP: `rsp_valid`=1, `rsp_data`/`rsp_rd` from registers. On `rsp_ready`, go to IDLE, or restart RUN if a new request is accepted the same cycle.
- `flush` behaviour:
  - In IDLE: no accept.
  - In RUN: go to DRAIN. The divider cannot abort, so its operands stay held.
  - In DRAIN: wait for `div_ready`, discard the result, go to IDLE.
  - In RESP: drop `rsp_valid` next cycle, go to IDLE; the response is not consumed even if `rsp_ready`=1.
  - `flush` has priority over all handshakes in the same cycle.
- `busy`=1 in RUN, DRAIN and RESP; the hazard unit stalls dependent issue on it.
- `req_op[2]`=0 is never issued to this block; the behaviour is undefined.

## Timing
- Accept in cycle T → `div_valid`=1 in T+1.
- `div_ready` in cycle D → `rsp_valid`=1 in D+1.
- Total latency is the divider latency + 2 cycles.
- Back-to-back: a response handshake and a new accept can occur in the same cycle, so there is zero idle cycles between divides.
- `div_stall`=0 in all states; the result register guarantees capture on `div_ready`.
- `div_ready` outside RUN/DRAIN is ignored.
- Reset mid-operation: the controller returns to IDLE asynchronously. The divider shares `rstn`, so no drain is needed.

## Configuration
- `DIV_FAST_PATH_EN` defined: special cases are resolved without starting the divider. On accept, the controller goes directly to RESP in the next cycle, `div_valid` stays 0, and latency is 1 cycle.
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Undefined: every request goes through the divider with normal latency.

## Test plan
- DIVU 100/7, tag 5, `rsp_ready`=1 → one `div_valid` pulse; `rsp_data`=14, `rsp_rd`=5 the cycle after `div_ready`; then IDLE.
- REM −7/2 followed back-to-back by DIV 20/−3 with `rsp_ready` held 1 → responses −1 (0xFFFFFFFF) then −6 (0xFFFFFFFA); the second is accepted in the first response's handshake cycle.
- DIV 9/3 with `rsp_ready`=0 for 10 cycles → `rsp_valid`, `rsp_data`=3 stable throughout; `req_ready`=0 until the handshake.
- DIVU 50/5 with `flush` 3 cycles after accept → DRAIN; operands held; no `rsp_valid`; IDLE one cycle after `div_ready`; a subsequent DIVU 8/2 returns 4.
- With `DIV_FAST_PATH_EN`: DIV 123/0 → 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF → 0. Both respond 1 cycle after accept with `div_valid` never asserted.
- `rstn` asserted in RUN and in RESP → all outputs 0 immediately; the next request completes normally.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: issue/completion controller for the iterative radix-2 RV32 divider.
// Optional macro DIV_FAST_PATH_EN resolves divide-by-zero and signed overflow without the divider.
module div_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   input  logic [4:0]  req_rd,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        busy,
   output logic        div_valid,
   output logic        div_stall,
   input  logic        div_ready,
   output logic [2:0]  div_op,
   output logic [31:0] div_op1,
   output logic [31:0] div_op2,
   input  logic [31:0] div_out
);
   // state | meaning
   // IDLE  | waiting for a request
   // RUN   | divider working; start pulse on the first cycle only
   // DRAIN | killed while the divider runs; wait for its result and drop it
   // RESP  | result held until writeback takes it
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_t;

   state_t      state_q, state_d;
   logic        start_q, start_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  rd_q, rd_d;
   logic        accept;
   logic        fast_hit;
   logic [31:0] fast_res;

`ifdef DIV_FAST_PATH_EN
   always_comb begin
      fast_hit = 1'b0;
      fast_res = '0;
      if (req_op2 == 32'h0) begin
         fast_hit = 1'b1;
         fast_res = req_op[1] ? req_op1 : 32'hFFFF_FFFF;
      end else if (!req_op[0] && req_op1 == 32'h8000_0000 && req_op2 == 32'hFFFF_FFFF) begin
         fast_hit = 1'b1;
         fast_res = req_op[1] ? 32'h0 : 32'h8000_0000;
      end
   end
`else
   assign fast_hit = 1'b0;
   assign fast_res = '0;
`endif

   // rstn is folded in so every output reads 0 while reset is held.
   assign req_ready = rstn & ~flush & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      op_d    = op_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      rd_d    = rd_q;
      res_d   = res_q;
      case (state_q)
         IDLE: ;
         RUN: begin
            if (flush) begin
               state_d = div_ready ? IDLE : DRAIN;
            end else if (div_ready) begin
               res_d   = div_out;
               state_d = RESP;
            end
         end
         DRAIN: begin
            if (div_ready) state_d = IDLE;
         end
         RESP: begin
            if (flush || rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         op_d  = req_op;
         op1_d = req_op1;
         op2_d = req_op2;
         rd_d  = req_rd;
         if (fast_hit) begin
            res_d   = fast_res;
            state_d = RESP;
         end else begin
            start_d = 1'b1;
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         op_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         op_q    <= op_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_data  = res_q;
   assign rsp_rd    = rd_q;
   assign div_valid = start_q & (state_q == RUN);
   assign div_stall = 1'b0;
   assign div_op    = op_q;
   assign div_op1   = op1_q;
   assign div_op2   = op2_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a fixed-latency divider model.
module tb_div_ctrl;
   localparam int LAT = 4;

   logic        clk, rstn, flush;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_op1, req_op2;
   logic [4:0]  req_rd;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        busy, div_valid, div_stall, div_ready;
   logic [2:0]  div_op;
   logic [31:0] div_op1, div_op2, div_out;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt     = 0;
   logic [31:0] mdl_res = '0;
   int waited;

   div_ctrl dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
      .busy(busy), .div_valid(div_valid), .div_stall(div_stall), .div_ready(div_ready),
      .div_op(div_op), .div_op1(div_op1), .div_op2(div_op2), .div_out(div_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op[1:0])
         2'b00:   ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(b));
         2'b01:   ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   ref_div = (b == 0) ? a : ovf ? 32'h0 : $unsigned($signed(a) % $signed(b));
         default: ref_div = (b == 0) ? a : a % b;
      endcase
   endfunction

   // Divider model: result LAT cycles after the start pulse, single-cycle strobe.
   initial begin
      div_ready = 1'b0;
      div_out   = '0;
      forever begin
         @(negedge clk);
         div_ready = 1'b0;
         div_out   = '0;
         if (!rstn) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               div_ready = 1'b1;
               div_out   = mdl_res;
            end
         end else if (div_valid) begin
            cnt     = LAT;
            mdl_res = ref_div(div_op, div_op1, div_op2);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int w);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_op1   = a;
      req_op2   = b;
      req_rd    = rd;
      #1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("accept_bound", 32'(n < 50), 32'd1);
      w = n;
      @(negedge clk);
      req_valid = 1'b0;
      req_op1   = 32'hDEAD_BEEF;
      req_op2   = 32'h1234_5678;
      req_rd    = 5'd31;
   endtask

   task automatic wait_rsp(input string tag, input logic [31:0] d, input logic [4:0] rd,
                           input int lat, input int pulses);
      int n;
      int p;
      n = 1;
      p = 0;
      #1;
      while (!rsp_valid && n < 100) begin
         if (div_valid) p++;
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_data"}, rsp_data, d);
      chk({tag, "_rd"}, 32'(rsp_rd), 32'(rd));
      chk({tag, "_pulses"}, p, pulses);
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
      req_op1 = '0; req_op2 = '0; req_rd = '0; rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_div_valid", 32'(div_valid), 0);
      chk("rst_div_stall", 32'(div_stall), 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("idle_req_ready", 32'(req_ready), 1);
      @(negedge clk);

      // DIVU 100/7
      rsp_ready = 1'b1;
      issue(3'b101, 32'd100, 32'd7, 5'd5, waited);
      #1;
      chk("t1_busy", 32'(busy), 1);
      chk("t1_div_op1", div_op1, 32'd100);
      wait_rsp("t1", 32'd14, 5'd5, LAT + 2, 1);
      @(negedge clk);
      #1;
      chk("t1_idle", 32'(busy), 0);

      // REM -7/2 then DIV 20/-3 back-to-back
      @(negedge clk);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, waited);
      wait_rsp("t2a", 32'hFFFF_FFFF, 5'd6, LAT + 2, 1);
      issue(3'b100, 32'd20, 32'hFFFF_FFFD, 5'd7, waited);
      chk("t2_b2b_wait", waited, 0);
      wait_rsp("t2b", 32'hFFFF_FFFA, 5'd7, LAT + 2, 1);
      @(negedge clk);

      // DIV 9/3 with writeback stalled 10 cycles
      rsp_ready = 1'b0;
      issue(3'b100, 32'd9, 32'd3, 5'd8, waited);
      wait_rsp("t3", 32'd3, 5'd8, LAT + 2, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk("t3_hold_valid", 32'(rsp_valid), 1);
         chk("t3_hold_data", rsp_data, 32'd3);
         chk("t3_hold_ready", 32'(req_ready), 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("t3_hs_ready", 32'(req_ready), 1);
      @(negedge clk);
      #1;
      chk("t3_done", 32'(rsp_valid), 0);
      chk("t3_idle", 32'(busy), 0);

      // DIVU 50/5 killed 3 cycles after accept
      @(negedge clk);
      issue(3'b101, 32'd50, 32'd5, 5'd10, waited);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("t4_flush_ready", 32'(req_ready), 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("t4_drain_busy", 32'(busy), 1);
      chk("t4_drain_rsp", 32'(rsp_valid), 0);
      chk("t4_drain_op", 32'(div_op), 32'(3'b101));
      chk("t4_drain_op1", div_op1, 32'd50);
      chk("t4_drain_op2", div_op2, 32'd5);
      @(negedge clk);
      #1;
      chk("t4_ready_cyc_busy", 32'(busy), 1);
      chk("t4_ready_cyc_rsp", 32'(rsp_valid), 0);
      @(negedge clk);
      #1;
      chk("t4_idle", 32'(busy), 0);
      chk("t4_no_rsp", 32'(rsp_valid), 0);
      @(negedge clk);
      issue(3'b101, 32'd8, 32'd2, 5'd11, waited);
      wait_rsp("t4b", 32'd4, 5'd11, LAT + 2, 1);
      @(negedge clk);

      // Flush in RESP beats a simultaneous response and request handshake
      rsp_ready = 1'b0;
      issue(3'b111, 32'd17, 32'd5, 5'd12, waited);
      wait_rsp("t5", 32'd2, 5'd12, LAT + 2, 1);
      @(negedge clk);
      flush = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("t5_flush_ready", 32'(req_ready), 0);
      @(negedge clk);
      flush = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("t5_rsp_dropped", 32'(rsp_valid), 0);
      chk("t5_idle", 32'(busy), 0);
      @(negedge clk);

      // Special cases
`ifdef DIV_FAST_PATH_EN
      issue(3'b100, 32'd123, 32'd0, 5'd13, waited);
      wait_rsp("t6a_fast", 32'hFFFF_FFFF, 5'd13, 1, 0);
      @(negedge clk);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, waited);
      wait_rsp("t6b_fast", 32'h0, 5'd14, 1, 0);
      @(negedge clk);
      issue(3'b111, 32'd77, 32'd0, 5'd15, waited);
      wait_rsp("t6c_fast", 32'd77, 5'd15, 1, 0);
      @(negedge clk);
`else
      issue(3'b100, 32'd123, 32'd0, 5'd13, waited);
      wait_rsp("t6a", 32'hFFFF_FFFF, 5'd13, LAT + 2, 1);
      @(negedge clk);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, waited);
      wait_rsp("t6b", 32'h0, 5'd14, LAT + 2, 1);
      @(negedge clk);
`endif

      // Reset in RUN
      issue(3'b101, 32'd100, 32'd7, 5'd16, waited);
      rstn = 1'b0;
      #1;
      chk("t7_run_busy", 32'(busy), 0);
      chk("t7_run_div_valid", 32'(div_valid), 0);
      chk("t7_run_div_op1", div_op1, 32'd0);
      chk("t7_run_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Reset in RESP
      rsp_ready = 1'b0;
      issue(3'b101, 32'd100, 32'd7, 5'd3, waited);
      wait_rsp("t8", 32'd14, 5'd3, LAT + 2, 1);
      rstn = 1'b0;
      #1;
      chk("t8_rsp_valid", 32'(rsp_valid), 0);
      chk("t8_rsp_data", rsp_data, 32'd0);
      chk("t8_rsp_rd", 32'(rsp_rd), 0);
      chk("t8_busy", 32'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      issue(3'b100, 32'd9, 32'd3, 5'd4, waited);
      wait_rsp("t8b", 32'd3, 5'd4, LAT + 2, 1);
      @(negedge clk);
      #1;
      chk("t8b_idle", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
